// File: rtl/mem_init_seq.sv
// Memory-fill sequencer: writes len words from base (wrapping at DEPTH) with a selectable pattern.
// Optional write backpressure port enabled by defining MEM_INIT_STALL_EN.
module mem_init_seq #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 8,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] base,
  input  logic [LW-1:0] len,
  input  logic [DW-1:0] fill_val,
`ifdef MEM_INIT_STALL_EN
  input  logic          stall,
`endif
  output logic          rdy,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wrdata,
  output logic          wren,
  output logic          done,
  output logic [1:0]    dbg_state
);

  // Handshake: a request is taken on the rising edge where en && rdy; inputs are
  // sampled only then. rdy is high exactly in IDLE and en at any other time is dropped.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);

  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [DW-1:0] fill_q, fill_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] offset_q, offset_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wrdata_q, wrdata_d;
  logic          wren_q, wren_d;
  logic          done_q, done_d;

  logic          hold;
  logic [LW-1:0] len_c;
  logic [AW-1:0] base_c;
  logic [AW-1:0] addr_nxt;

`ifdef MEM_INIT_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  function automatic logic [DW-1:0] pattern(input logic [1:0] m, input logic [AW-1:0] a,
                                            input logic [DW-1:0] f);
    logic [DW-1:0] r;
    case (m)
      2'd0:    r = DW'(a);
      2'd1:    r = f;
      2'd2:    r = DW'(LAST_ADDR - a);
      default: r = DW'(a) + f;
    endcase
    return r;
  endfunction

  // When DEPTH is not a power of two a base beyond the last entry folds back once.
  assign len_c    = (len > DEPTH_L) ? DEPTH_L : len;
  assign base_c   = ({1'b0, base} >= DEPTH_W) ? (base - AW'(DEPTH)) : base;
  assign addr_nxt = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    fill_d   = fill_q;
    len_d    = len_q;
    offset_d = offset_q;
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    wren_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          mode_d   = mode;
          fill_d   = fill_val;
          len_d    = len_c;
          offset_d = '0;
          if (len_c != '0) begin
            state_d  = FILL;
            wren_d   = 1'b1;
            addr_d   = base_c;
            wrdata_d = pattern(mode, base_c, fill_val);
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      FILL: begin
        if (hold) begin
          wren_d = wren_q;
        end else if (offset_q == len_q - 1'b1) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          offset_d = offset_q + 1'b1;
          addr_d   = addr_nxt;
          wrdata_d = pattern(mode_q, addr_nxt, fill_q);
          wren_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= '0;
      fill_q   <= '0;
      len_q    <= '0;
      offset_q <= '0;
      addr_q   <= '0;
      wrdata_q <= '0;
      wren_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      fill_q   <= fill_d;
      len_q    <= len_d;
      offset_q <= offset_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      wren_q   <= wren_d;
      done_q   <= done_d;
    end
  end

  // A stalled cycle suppresses the pending write while address and data hold.
  assign wren      = wren_q & ~hold;
  assign rdy       = (state_q == IDLE);
  assign addr      = addr_q;
  assign wrdata    = wrdata_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
